// File: rtl/sc_loader_pkg.sv
// ---------------------------------------------------------------------------
// sc_loader_pkg
// Shared constants and types for the instruction-memory boot loader.
//   DEPTH      : instruction memory depth in words (also the largest frame)
//   AW         : word address width, clog2(DEPTH)
//   CSUM_W     : width of the running frame checksum
//   loader_state_e : loader FSM states
//   lenValid() : true when a length byte names a loadable frame size
// ---------------------------------------------------------------------------
package sc_loader_pkg;

  localparam int DEPTH  = 32;
  localparam int AW     = 5;
  localparam int CSUM_W = 8;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  // A frame must carry at least one word and must fit in the memory.
  function automatic logic lenValid(input logic [7:0] n);
    return (n != 8'd0) && (n <= 8'(DEPTH));
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// ---------------------------------------------------------------------------
// imem_word_packer
// Collects four stream bytes into one little-endian 32-bit word.
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   byteStrobe_i : byte_i is a data byte to pack this cycle
//   byte_i       : data byte
//   clear_i      : restart packing at byte 0 (discard any partial word)
//   word_o       : assembled word, valid while wordDone_o is high
//   wordDone_o   : the byte taken this cycle completes a word
// ---------------------------------------------------------------------------
module imem_word_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byteStrobe_i,
  input  logic [7:0]  byte_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        wordDone_o
);

  logic [1:0]  byteIdx_q, byteIdx_d;
  logic [23:0] lowBytes_q, lowBytes_d;

  // Only the first three bytes need storing. Each new byte enters at the top
  // and slides down, so after three strobes the first byte sits in [7:0].
  // The fourth byte is placed straight into [31:24] of the output, which
  // lets the word be presented in the same cycle its last byte arrives.
  always_comb begin
    byteIdx_d  = byteIdx_q;
    lowBytes_d = lowBytes_q;
    if (clear_i) begin
      byteIdx_d  = 2'd0;
      lowBytes_d = 24'd0;
    end else if (byteStrobe_i) begin
      byteIdx_d  = byteIdx_q + 2'd1;
      lowBytes_d = {byte_i, lowBytes_q[23:8]};
    end
  end

  // Byte counter and partial-word storage; reset discards any partial word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byteIdx_q  <= 2'd0;
      lowBytes_q <= 24'd0;
    end else begin
      byteIdx_q  <= byteIdx_d;
      lowBytes_q <= lowBytes_d;
    end
  end

  // The counter wraps 3 -> 0 on its own, so no extra clear is needed per word.
  assign word_o     = {byte_i, lowBytes_q};
  assign wordDone_o = byteStrobe_i & ~clear_i & (byteIdx_q == 2'd3);

endmodule

// File: rtl/sc_imem_loader.sv
// ---------------------------------------------------------------------------
// sc_imem_loader
// Boot loader for the single-cycle core's writable instruction memory.
// Accepts a framed byte stream (length N, 4*N little-endian instruction
// bytes, 8-bit additive checksum) and writes the words to consecutive word
// addresses starting at 0. The core is held in reset until a frame with a
// matching checksum has been written.
//   clk_i           : clock, rising edge
//   rst_i           : asynchronous active-high reset
//   in_data_i       : stream byte
//   in_valid_i      : in_data_i is valid
//   in_ready_o      : loader accepts a byte this cycle
//   restart_i       : re-arm pulse, honoured only in DONE or ERR
//   im_we_o         : one-cycle instruction memory write strobe
//   im_addr_o       : word address of the write
//   im_wdata_o      : instruction word of the write
//   cpu_hold_o      : keeps the core in reset while high
//   load_done_o     : image written and checksum verified
//   load_err_o      : bad length or checksum
//   words_written_o : words written so far in the current frame
// ---------------------------------------------------------------------------
module sc_imem_loader
  import sc_loader_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          restart_i,
  output logic          im_we_o,
  output logic [AW-1:0] im_addr_o,
  output logic [31:0]   im_wdata_o,
  output logic          cpu_hold_o,
  output logic          load_done_o,
  output logic          load_err_o,
  output logic [AW:0]   words_written_o
);

  loader_state_e     state_q;
  logic              inReady_q;
  logic              imWe_q;
  logic [AW-1:0]     imAddr_q;
  logic [31:0]       imWdata_q;
  logic              cpuHold_q;
  logic              loadDone_q;
  logic              loadErr_q;
  logic [AW:0]       wordsWritten_q;
  logic [AW:0]       frameLen_q;
  logic [CSUM_W-1:0] csum_q;

  logic        xfer;
  logic        packStrobe;
  logic        packClear;
  logic [31:0] packWord;
  logic        packDone;

  // A byte moves only when the registered ready and the sender's valid meet.
  // The length byte clears the packer so every frame starts on byte 0.
  assign xfer       = in_valid_i & inReady_q;
  assign packStrobe = xfer & (state_q == ST_DATA);
  assign packClear  = xfer & (state_q == ST_LEN);

  imem_word_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byteStrobe_i (packStrobe),
    .byte_i       (in_data_i),
    .clear_i      (packClear),
    .word_o       (packWord),
    .wordDone_o   (packDone)
  );

  // Loader FSM with all outputs registered. words_written doubles as the
  // word index: it is AW+1 bits so a full 32-word frame can be counted, and
  // its low AW bits are the address of the word being written. in_ready is
  // set on each transition so it is already low in the cycle DONE/ERR is
  // entered, and it comes up one cycle after reset is released.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_LEN;
      inReady_q      <= 1'b0;
      imWe_q         <= 1'b0;
      imAddr_q       <= '0;
      imWdata_q      <= 32'd0;
      cpuHold_q      <= 1'b1;
      loadDone_q     <= 1'b0;
      loadErr_q      <= 1'b0;
      wordsWritten_q <= '0;
      frameLen_q     <= '0;
      csum_q         <= '0;
    end else begin
      imWe_q <= 1'b0;
      case (state_q)
        ST_LEN: begin
          inReady_q <= 1'b1;
          if (xfer) begin
            if (!lenValid(in_data_i)) begin
              state_q   <= ST_ERR;
              loadErr_q <= 1'b1;
              inReady_q <= 1'b0;
            end else begin
              frameLen_q     <= in_data_i[AW:0];
              wordsWritten_q <= '0;
              csum_q         <= '0;
              state_q        <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (xfer) begin
            csum_q <= csum_q + in_data_i;
            if (packDone) begin
              imWe_q         <= 1'b1;
              imAddr_q       <= wordsWritten_q[AW-1:0];
              imWdata_q      <= packWord;
              wordsWritten_q <= wordsWritten_q + (AW+1)'(1);
              if (wordsWritten_q + (AW+1)'(1) == frameLen_q) begin
                state_q <= ST_CSUM;
              end
            end
          end
        end

        ST_CSUM: begin
          if (xfer) begin
            inReady_q <= 1'b0;
            if (in_data_i == csum_q) begin
              state_q    <= ST_DONE;
              loadDone_q <= 1'b1;
              cpuHold_q  <= 1'b0;
            end else begin
              state_q   <= ST_ERR;
              loadErr_q <= 1'b1;
            end
          end
        end

        ST_DONE, ST_ERR: begin
          if (restart_i) begin
            state_q        <= ST_LEN;
            inReady_q      <= 1'b1;
            cpuHold_q      <= 1'b1;
            loadDone_q     <= 1'b0;
            loadErr_q      <= 1'b0;
            wordsWritten_q <= '0;
          end
        end

        default: begin
          state_q   <= ST_LEN;
          inReady_q <= 1'b0;
          cpuHold_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o      = inReady_q;
  assign im_we_o         = imWe_q;
  assign im_addr_o       = imAddr_q;
  assign im_wdata_o      = imWdata_q;
  assign cpu_hold_o      = cpuHold_q;
  assign load_done_o     = loadDone_q;
  assign load_err_o      = loadErr_q;
  assign words_written_o = wordsWritten_q;

endmodule

// File: tb/tb_sc_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_sc_imem_loader
// Self-checking bench for sc_imem_loader. Frames are built as byte lists;
// the expected writes, flags and write timing are derived from the frame
// format rules (length, little-endian words, sum-mod-256 checksum).
// ---------------------------------------------------------------------------
module tb_sc_imem_loader;
  import sc_loader_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          restart = 1'b0;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_written;

  int compared   = 0;
  int mismatched = 0;
  int cycleCnt   = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t        wrQ[$];
  logic [7:0] stream[$];
  int         accCyc[$];

  sc_imem_loader dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_data_i       (in_data),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .restart_i       (restart),
    .im_we_o         (im_we),
    .im_addr_o       (im_addr),
    .im_wdata_o      (im_wdata),
    .cpu_hold_o      (cpu_hold),
    .load_done_o     (load_done),
    .load_err_o      (load_err),
    .words_written_o (words_written)
  );

  // Free-running clock and cycle counter used to time-stamp events.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Record every memory write seen between clock edges.
  always @(negedge clk) begin
    if (im_we === 1'b1) wrQ.push_back('{int'(im_addr), im_wdata, cycleCnt});
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte until it is taken (bounded), then idle for gap cycles.
  // Called and returns on a falling edge; the stored cycle stamp is the
  // cycle that starts with the accepting edge.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    bit acc;
    int waitCnt;
    acc     = 1'b0;
    waitCnt = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!acc && waitCnt < 64) begin
      acc = (in_ready === 1'b1);
      @(negedge clk);
      waitCnt++;
    end
    in_valid = 1'b0;
    if (acc) begin
      accCyc.push_back(cycleCnt);
    end else begin
      accCyc.push_back(-1);
      compared++;
      mismatched++;
      $display("[TB] FAIL handshake: observed in_ready low for %0d cycles, expected byte accepted", waitCnt);
    end
    repeat (gap) @(negedge clk);
  endtask

  // Pulse restart for one cycle and check the loader is re-armed.
  task automatic restartLoader(input string tag);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checkOutput({tag, " rearm hold"}, 64'(cpu_hold), 64'd1);
    checkOutput({tag, " rearm done"}, 64'(load_done), 64'd0);
    checkOutput({tag, " rearm err"}, 64'(load_err), 64'd0);
    checkOutput({tag, " rearm words"}, 64'(words_written), 64'd0);
    checkOutput({tag, " rearm ready"}, 64'(in_ready), 64'd1);
  endtask

  // Build a frame of n random words; bump is added to the true checksum.
  // With fixWord1, word 1 is the instruction 0x0500E213.
  task automatic buildFrame(input int n, input int bump, input bit fixWord1);
    logic [7:0] sum;
    logic [7:0] b;
    stream.delete();
    stream.push_back(8'(n));
    sum = 8'd0;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (fixWord1 && i == 4) b = 8'h13;
      if (fixWord1 && i == 5) b = 8'hE2;
      if (fixWord1 && i == 6) b = 8'h00;
      if (fixWord1 && i == 7) b = 8'h05;
      stream.push_back(b);
      sum = sum + b;
    end
    stream.push_back(sum + 8'(bump));
  endtask

  // Send the frame in 'stream' and check writes, timing and final flags.
  // restartAt >= 0 pulses restart just before that byte index.
  task automatic runFrame(input string tag, input int gapMax, input int restartAt);
    int         n;
    int         nBytes;
    int         expWords;
    int         nCmp;
    bit         lenOk;
    bit         expDone;
    logic [7:0] sum;
    logic [31:0] w;
    wrQ.delete();
    accCyc.delete();
    n        = int'(stream[0]);
    lenOk    = (n >= 1) && (n <= DEPTH);
    nBytes   = lenOk ? 4 * n + 2 : 1;
    expWords = lenOk ? n : 0;
    for (int i = 0; i < nBytes; i++) begin
      if (i == restartAt) begin
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
      end
      applyStimulus(stream[i], (i == nBytes - 1) ? 0 : $urandom_range(0, gapMax));
    end
    sum = 8'd0;
    for (int k = 0; k < 4 * expWords; k++) sum = sum + stream[1 + k];
    expDone = lenOk && (stream[nBytes - 1] == sum);

    checkOutput({tag, " done"}, 64'(load_done), 64'(expDone));
    checkOutput({tag, " err"}, 64'(load_err), 64'(!expDone));
    checkOutput({tag, " hold"}, 64'(cpu_hold), 64'(!expDone));
    checkOutput({tag, " ready"}, 64'(in_ready), 64'd0);
    checkOutput({tag, " words"}, 64'(words_written), 64'(expWords));

    repeat (3) @(negedge clk);
    checkOutput({tag, " write count"}, 64'(wrQ.size()), 64'(expWords));
    checkOutput({tag, " ready held"}, 64'(in_ready), 64'd0);
    nCmp = (wrQ.size() < expWords) ? wrQ.size() : expWords;
    for (int k = 0; k < nCmp; k++) begin
      w = {stream[4*k+4], stream[4*k+3], stream[4*k+2], stream[4*k+1]};
      checkOutput($sformatf("%s w%0d addr", tag, k), 64'(wrQ[k].addr), 64'(k));
      checkOutput($sformatf("%s w%0d data", tag, k), 64'(wrQ[k].data), 64'(w));
      checkOutput($sformatf("%s w%0d cycle", tag, k), 64'(wrQ[k].cyc), 64'(accCyc[4*k+4]));
    end
  endtask

  initial begin
    $display("[TB] start");
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset ready", 64'(in_ready), 64'd0);
    checkOutput("reset we", 64'(im_we), 64'd0);
    checkOutput("reset addr", 64'(im_addr), 64'd0);
    checkOutput("reset wdata", 64'(im_wdata), 64'd0);
    checkOutput("reset hold", 64'(cpu_hold), 64'd1);
    checkOutput("reset done", 64'(load_done), 64'd0);
    checkOutput("reset err", 64'(load_err), 64'd0);
    checkOutput("reset words", 64'(words_written), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle ready", 64'(in_ready), 64'd1);
    checkOutput("idle hold", 64'(cpu_hold), 64'd1);
    checkOutput("idle we", 64'(im_we), 64'd0);

    // Single word 0x000000B7.
    stream.delete();
    stream = '{8'h01, 8'hB7, 8'h00, 8'h00, 8'h00, 8'hB7};
    runFrame("single", 0, -1);
    restartLoader("single");

    // Full 32-word image with random gaps.
    buildFrame(32, 0, 1'b1);
    runFrame("full", 2, -1);
    restartLoader("full");

    // Bad checksum; a restart pulse mid-frame must be ignored.
    buildFrame(2, 1, 1'b0);
    runFrame("badcsum", 1, 3);
    restartLoader("badcsum");

    // Bad lengths.
    stream.delete();
    stream.push_back(8'h00);
    runFrame("len0", 0, -1);
    restartLoader("len0");
    stream.delete();
    stream.push_back(8'h21);
    runFrame("len33", 0, -1);
    restartLoader("len33");

    // Random frames, some with a corrupted checksum.
    for (int f = 0; f < 4; f++) begin
      buildFrame($urandom_range(1, DEPTH), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 255), 1'b0);
      runFrame($sformatf("rand%0d", f), 3, -1);
      restartLoader($sformatf("rand%0d", f));
    end

    // Reset in the middle of a frame: 2 words announced, 6 bytes sent.
    wrQ.delete();
    accCyc.delete();
    applyStimulus(8'h02, 0);
    for (int i = 0; i < 6; i++) applyStimulus(8'($urandom_range(0, 255)), 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst words", 64'(words_written), 64'd0);
    checkOutput("midrst ready", 64'(in_ready), 64'd0);
    checkOutput("midrst hold", 64'(cpu_hold), 64'd1);
    checkOutput("midrst we", 64'(im_we), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst writes", 64'(wrQ.size()), 64'd1);
    checkOutput("midrst ready after", 64'(in_ready), 64'd1);
    buildFrame(1, 0, 1'b0);
    runFrame("afterrst", 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
